// File: rtl/hamming_secded_decoder.sv
// Extended-Hamming (SECDED) decoder: 2-stage valid/ready pipeline with
// optional single-bit correction and saturating error-event counters.
module hamming_secded_decoder #(
  parameter int P     = 3,
  parameter int CNT_W = 8,
  localparam int DATA_W = (1 << P) - P - 1,
  localparam int CW_W   = (1 << P)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_data,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syndrome,
  output logic              out_corr,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  // Codeword position of data bit j: the j-th non-power-of-two index.
  function automatic int dataPos(input int j);
    int cnt;
    cnt     = 0;
    dataPos = 0;
    for (int k = 1; k < CW_W; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (cnt == j) dataPos = k;
        cnt++;
      end
    end
  endfunction

  logic              r_s1Valid;
  logic [CW_W-1:0]   r_s1Cw;
  logic [P-1:0]      r_s1Syn;
  logic              r_s1Op;
  logic              r_s1Mode;

  logic              r_outValid;
  logic [DATA_W-1:0] r_outData;
  logic [P-1:0]      r_outSyn;
  logic              r_outCorr;
  logic              r_outUncorr;
  logic [CNT_W-1:0]  r_corrCnt;
  logic [CNT_W-1:0]  r_uncorrCnt;

  logic              w_s2Adv;
  logic              w_s1Adv;
  logic              w_outXfer;
  logic [P-1:0]      w_syn;
  logic              w_op;
  logic [CW_W-1:0]   w_fixed;
  logic [DATA_W-1:0] w_data;
  logic              w_corr;
  logic              w_uncorr;

  assign w_s2Adv   = !r_outValid || out_ready;
  assign w_s1Adv   = !r_s1Valid || w_s2Adv;
  assign in_ready  = !rst && w_s1Adv;
  assign w_outXfer = r_outValid && out_ready;

  always_comb begin
    w_syn = '0;
    w_op  = 1'b0;
    for (int k = 0; k < CW_W; k++) begin
      if (in_data[k]) w_syn = w_syn ^ P'(k);
      w_op = w_op ^ in_data[k];
    end
  end

  // Overall parity alone distinguishes a single error (odd) from a double (even).
  always_comb begin
    w_corr   = r_s1Op;
    w_uncorr = !r_s1Op && (r_s1Syn != '0);
    w_fixed  = r_s1Cw;
    if (r_s1Mode && r_s1Op && (r_s1Syn != '0))
      w_fixed[r_s1Syn] = ~r_s1Cw[r_s1Syn];
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_extract
    assign w_data[j] = w_fixed[dataPos(j)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Cw    <= '0;
      r_s1Syn   <= '0;
      r_s1Op    <= 1'b0;
      r_s1Mode  <= 1'b0;
    end else if (w_s1Adv) begin
      r_s1Valid <= in_valid;
      r_s1Cw    <= in_data;
      r_s1Syn   <= w_syn;
      r_s1Op    <= w_op;
      r_s1Mode  <= correct_en;
    end
  end

  // Output fields are forced to zero whenever the stage holds no beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_outSyn    <= '0;
      r_outCorr   <= 1'b0;
      r_outUncorr <= 1'b0;
    end else if (w_s2Adv) begin
      r_outValid  <= r_s1Valid;
      r_outData   <= r_s1Valid ? w_data : '0;
      r_outSyn    <= r_s1Valid ? r_s1Syn : '0;
      r_outCorr   <= r_s1Valid && w_corr;
      r_outUncorr <= r_s1Valid && w_uncorr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_corrCnt   <= '0;
      r_uncorrCnt <= '0;
    end else if (w_outXfer) begin
      if (r_outCorr && (r_corrCnt != '1))
        r_corrCnt <= r_corrCnt + 1'b1;
      if (r_outUncorr && (r_uncorrCnt != '1))
        r_uncorrCnt <= r_uncorrCnt + 1'b1;
    end
  end

  assign out_valid    = r_outValid;
  assign out_data     = r_outData;
  assign out_syndrome = r_outSyn;
  assign out_corr     = r_outCorr;
  assign out_uncorr   = r_outUncorr;
  assign corr_cnt     = r_corrCnt;
  assign uncorr_cnt   = r_uncorrCnt;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder (P=3, CNT_W=4): decode cases,
// counters, backpressure ordering and mid-stream reset.
module tb_hamming_secded_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       correct_en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic       out_corr;
  logic       out_uncorr;
  logic       cnt_clr;
  logic [3:0] corr_cnt;
  logic [3:0] uncorr_cnt;

  int testsRun    = 0;
  int testsFailed = 0;

  hamming_secded_decoder #(.P(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .correct_en(correct_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_corr(out_corr), .out_uncorr(out_uncorr),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One beat with out_ready high; mode is flipped after the handshake so a
  // late sample of correct_en would show up in the decoded data.
  task automatic applyStimulus(input logic [7:0] cw, input logic mode,
                               input logic [3:0] expData, input logic [2:0] expSyn,
                               input logic expCorr, input logic expUncorr,
                               input string tag);
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = cw;
    correct_en = mode;
    @(negedge clk);
    in_valid   = 1'b0;
    correct_en = ~mode;
    checkOutput({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"},  32'(out_valid),    32'd1);
    checkOutput({tag, "_data"},   32'(out_data),     32'(expData));
    checkOutput({tag, "_syn"},    32'(out_syndrome), 32'(expSyn));
    checkOutput({tag, "_corr"},   32'(out_corr),     32'(expCorr));
    checkOutput({tag, "_uncorr"}, 32'(out_uncorr),   32'(expUncorr));
    @(negedge clk);
  endtask

  initial begin
    int outBeats;
    int inBeats;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    correct_en = 1'b1;
    out_ready  = 1'b1;
    cnt_clr    = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    checkOutput("rst_corr_cnt",  32'(corr_cnt),  32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(8'hAA, 1'b1, 4'hB, 3'd0, 1'b0, 1'b0, "clean");
    checkOutput("clean_corr_cnt", 32'(corr_cnt), 32'd0);
    applyStimulus(8'h8A, 1'b1, 4'hB, 3'd5, 1'b1, 1'b0, "single5");
    checkOutput("single5_corr_cnt", 32'(corr_cnt), 32'd1);
    applyStimulus(8'hAB, 1'b1, 4'hB, 3'd0, 1'b1, 1'b0, "single0");
    checkOutput("single0_corr_cnt", 32'(corr_cnt), 32'd2);
    applyStimulus(8'h8A, 1'b0, 4'h9, 3'd5, 1'b1, 1'b0, "detect_only");
    applyStimulus(8'hAC, 1'b1, 4'hB, 3'd3, 1'b0, 1'b1, "double");
    checkOutput("double_uncorr_cnt", 32'(uncorr_cnt), 32'd1);
    checkOutput("double_corr_cnt",   32'(corr_cnt),   32'd3);

    // 20 back-to-back single-error beats: full throughput and saturation.
    outBeats = 0;
    inBeats  = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (out_valid) outBeats++;
      if (in_valid && in_ready) inBeats++;
      in_valid   = (c < 20);
      in_data    = 8'h8A;
      correct_en = 1'b1;
    end
    checkOutput("stream_in_beats",  32'(inBeats),  32'd20);
    checkOutput("stream_out_beats", 32'(outBeats), 32'd20);
    checkOutput("sat_corr_cnt",     32'(corr_cnt), 32'd15);

    // Clear coincides with an output transfer of a correctable beat.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h8A;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("clr_beat_valid", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    checkOutput("clr_corr_cnt",   32'(corr_cnt),   32'd0);
    checkOutput("clr_uncorr_cnt", 32'(uncorr_cnt), 32'd0);

    // Backpressure: two beats fill the pipe, the third must wait.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    @(negedge clk);
    in_data = 8'h8A;
    @(negedge clk);
    in_data = 8'hAC;
    checkOutput("bp_in_ready_full", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_stall_valid", 32'(out_valid),    32'd1);
      checkOutput("bp_stall_data",  32'(out_data),     32'hB);
      checkOutput("bp_stall_syn",   32'(out_syndrome), 32'd0);
      checkOutput("bp_stall_ready", 32'(in_ready),     32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_beat2_syn",  32'(out_syndrome), 32'd5);
    checkOutput("bp_beat2_corr", 32'(out_corr),     32'd1);
    @(negedge clk);
    checkOutput("bp_beat3_syn",    32'(out_syndrome), 32'd3);
    checkOutput("bp_beat3_uncorr", 32'(out_uncorr),   32'd1);
    @(negedge clk);
    checkOutput("bp_drained",    32'(out_valid),  32'd0);
    checkOutput("bp_corr_cnt",   32'(corr_cnt),   32'd1);
    checkOutput("bp_uncorr_cnt", 32'(uncorr_cnt), 32'd1);

    // Reset with two beats in flight: neither may ever emerge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAC;
    @(negedge clk);
    in_data = 8'h8A;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("midrst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid",  32'(out_valid),  32'd0);
    checkOutput("midrst_corr_cnt",   32'(corr_cnt),   32'd0);
    checkOutput("midrst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    checkOutput("midrst_in_ready",   32'(in_ready),   32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    outBeats  = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) outBeats++;
    end
    checkOutput("midrst_ghost_beats", 32'(outBeats), 32'd0);
    applyStimulus(8'hAC, 1'b1, 4'hB, 3'd3, 1'b0, 1'b1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hamming_secded_decoder.md
HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 SHALL have parameter P, default 3: number of Hamming parity bits, legal range 3..6.
REQ-002 SHALL have parameter CNT_W, default 8: width of the error counters, legal range 1..16.
REQ-003 SHALL derive DATA_W = 2^P - P - 1 and CW_W = 2^P; P=3 gives 4 data bits and an 8-bit codeword.
REQ-004 SHALL have a single clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: input codeword is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept a codeword.
REQ-009 SHALL have port in_data, input, CW_W bits: extended Hamming codeword.
REQ-010 SHALL have port correct_en, input, 1 bit: 1 = correct single errors, 0 = detect-only.
REQ-011 SHALL have port out_valid, output, 1 bit: output beat is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the output beat.
REQ-013 SHALL have port out_data, output, DATA_W bits: decoded data.
REQ-014 SHALL have port out_syndrome, output, P bits: Hamming syndrome of the beat.
REQ-015 SHALL have port out_corr, output, 1 bit: single-bit error detected on the beat.
REQ-016 SHALL have port out_uncorr, output, 1 bit: double-bit error detected on the beat.
REQ-017 SHALL have port cnt_clr, input, 1 bit: clear both counters.
REQ-018 SHALL have port corr_cnt, output, CNT_W bits: count of beats with single-bit errors.
REQ-019 SHALL have port uncorr_cnt, output, CNT_W bits: count of beats with double-bit errors.

Function
REQ-020 SHALL use this codeword layout: bit 0 is overall parity; bit k (1..CW_W-1) is Hamming position k; positions that are powers of two are parity bits; data bit j occupies the j-th non-power-of-two position, ascending (data[0] at bit 3).
REQ-021 SHALL compute syndrome s as the XOR of the indices k>=1 of all set bits, and overall parity op as the XOR of all CW_W bits.
REQ-022 SHALL classify each beat as follows:
- s=0, op=0: no error.
- s!=0, op=1: single error at bit s; out_corr=1.
- s=0, op=1: single error at bit 0; out_corr=1, data unaffected.
- s!=0, op=0: double error; out_uncorr=1, data extracted uncorrected.
REQ-023 SHALL, when correct_en=1 and the single-error case with s!=0 applies, invert bit s before data extraction; when correct_en=0 it SHALL never modify data, while flags and syndrome are still reported.
REQ-024 SHALL sample correct_en together with in_data on the input handshake.
REQ-025 SHALL be a 2-stage pipeline: stage 1 registers the codeword, s, op and mode; stage 2 registers the out_* signals.
REQ-026 SHALL have a latency of exactly 2 clk cycles from the input handshake to out_valid when out_ready is held high; throughput SHALL be 1 beat per cycle.
REQ-027 SHALL use these handshakes: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-028 SHALL advance stage 2 when !out_valid || out_ready, and advance stage 1 when stage 1 is empty or stage 2 advances.
REQ-029 SHALL drive in_ready = stage 1 empty || stage 1 advancing, which is combinational from out_ready.
REQ-030 SHALL hold out_data, out_syndrome, out_corr and out_uncorr stable while out_valid && !out_ready.
REQ-031 SHALL never drop, duplicate or reorder beats; maximum occupancy is 2 beats.
REQ-032 SHALL increment a counter only on an output transfer with the matching flag.
REQ-033 SHALL saturate each counter at 2^CNT_W - 1, with no wrap.
REQ-034 SHALL, when cnt_clr is high, set both counters to 0 on the next edge; cnt_clr takes priority over a simultaneous increment.
REQ-035 SHALL hold out_data, out_syndrome, out_corr and out_uncorr at 0 whenever out_valid=0.

Reset
REQ-036 SHALL, on rst high at a clock edge, set out_valid=0, empty both stages, set all out_* data/flag outputs to 0, and set both counters to 0.
REQ-037 SHALL hold in_ready at 0 during rst and return it to 1 on the first cycle after rst deasserts.
REQ-038 SHALL discard beats in flight when rst is asserted mid-operation, with no output transfer for them.

Verification (P=3, CNT_W=4)
REQ-039 Clean beat: in_data=0xAA, correct_en=1 -> 2 cycles later out_data=0xB, out_syndrome=0, out_corr=0, out_uncorr=0.
REQ-040 Single errors:
- 0x8A (bit 5 flipped) -> out_data=0xB, syndrome=5, out_corr=1, corr_cnt=1.
- 0xAB (bit 0 flipped) -> out_data=0xB, syndrome=0, out_corr=1.
- 0x8A with correct_en=0 -> out_data=0x9, out_corr=1.
REQ-041 Double error: 0xAC (bits 1,2 flipped) -> syndrome=3, out_uncorr=1, out_corr=0, out_data=0xB, uncorr_cnt=1.
REQ-042 Counters: 20 consecutive 0x8A beats -> corr_cnt saturates at 15; cnt_clr asserted on the same cycle as an output transfer of a 0x8A beat -> corr_cnt=0 on the next cycle.
REQ-043 Backpressure: out_ready=0, offer 0xAA, 0x8A, 0xAC back-to-back -> first two accepted, in_ready=0 for the third; raise out_ready -> outputs in order 0xAA, 0x8A, 0xAC, with beats stable while stalled.
REQ-044 Reset mid-stream: rst asserted with 2 beats in flight -> next cycle out_valid=0 and counters=0, and neither beat ever appears on the output.
